ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Consumes the ID/EX register outputs and selects forwarded operands.
- Computes the ALU result, including an iterative 32-cycle multiplier that stalls the front of the pipeline.
- Registers results into the EX/MEM boundary for the MEM stage.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations; fixed to the operand width.

Ports:
- clk_i  in  1  clock
- start_i  in  1  async active-low reset
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  control from ID/EX
- ALUOp_i  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- RS1data_i, RS2data_i, ImmGen_i  in  32 each  operands from ID/EX
- funct_7_3_i  in  10  {funct7, funct3}
- RDaddr_i  in  5  destination register
- ForwardA_i, ForwardB_i  in  2 each  00 register, 10 EX/MEM, 01 MEM/WB, 11 treated as 00
- EXMEMfwd_i, MEMWBfwd_i  in  32 each  forwarding data
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  EX/MEM control
- ALUResult_o  out  32  EX/MEM result
- RS2data_o  out  32  forwarded B operand, used as store data
- RDaddr_o  out  5  EX/MEM destination
- stall_o  out  1  hold PC, IF/ID and ID/EX; combinational

Behaviour:
- Clock/reset: one clock, clk_i, rising edge. start_i is asynchronous, active-low.
- While start_i is low: all outputs 0, state IDLE, counter 0, multiplier registers 0. Reset mid-multiply abandons the operation with no result.
- Operands:
  - opA = fwd(ForwardA_i, RS1data_i).
  - fwdB = fwd(ForwardB_i, RS2data_i).
  - opB = ALUSrc_i ? ImmGen_i : fwdB.
- Decode:
  - ALUOp 00 -> add. ALUOp 01 -> sub.
  - ALUOp 10, by {funct7, funct3}:
    - 0000000_000 add, 0100000_000 sub
    - 0000000_111 and, 0000000_110 or, 0000000_100 xor
    - 0000000_001 sll (shift amount opB[4:0])
    - 0000001_000 mul
  - ALUOp 11: funct3 000 -> addi; funct3 101 with funct7 0100000 -> srai (arithmetic shift, shift amount ImmGen_i[4:0]).
  - Any other code -> result 0.
  - All arithmetic is modulo 2^32.
- is_mul = (ALUOp_i==10 && funct_7_3_i==0000001_000).
- State machine IDLE / BUSY / DONE:
  - IDLE, is_mul=0: single cycle. EX/MEM loads control, ALU result, fwdB and RDaddr at the edge. stall_o=0.
  - IDLE, is_mul=1: stall_o=1. Latch multiplicand opA, multiplier fwdB, product 0, count 0. Go to BUSY.
  - BUSY: stall_o=1. Each cycle: if multiplier[0] is 1, add multiplicand to product; shift multiplicand left 1 and multiplier right 1; count+1. After count reaches MUL_CYCLES-1, go to DONE.
  - DONE: stall_o=0 and is_mul is ignored. EX/MEM loads product[31:0] with the current control/RDaddr. Next state IDLE.
- mul latency: stall_o is high for 33 cycles; the result appears in ALUResult_o on the 34th edge after entry.
- Back-to-back mul: the second mul enters EX in the cycle after DONE and is seen in IDLE, so it restarts cleanly.
- During stall (IDLE-with-mul and BUSY) EX/MEM loads a bubble: all four control bits 0, ALUResult_o 0, RDaddr_o 0. Operands are latched at entry, so forwarding changes during the stall have no effect.

Optional Feature:
- Macro EX_MUL_FAST_EN.
- Defined: mul is single-cycle combinational (opA*opB low 32 bits). No BUSY/DONE states; stall_o is tied 0.
- Undefined: iterative multiplier exactly as specified above.

Decomposition:
- Shared package holds:
  - ALUOp codes.
  - Forward select codes.
  - The ten funct_7_3 constants.
  - State encoding: IDLE=0, BUSY=1, DONE=2.
- Sub-module: iter_mul, containing the BUSY datapath and counter, with a start/done handshake. Forwarding, decode, FSM and the EX/MEM register stay in ex_stage.

Test Plan:
- Reset: drive inputs with random values and hold start_i=0 -> every output 0, stall_o=0. Assert start_i=1 mid-mul (cycle 10) then pull it low -> outputs 0, state IDLE.
- add with forwarding: RS1data=5, EXMEMfwd=7, ForwardA=10, RS2data=3, ALUOp=10, funct 0000000_000, RegWrite=1, RDaddr=4 -> next edge ALUResult_o=10, RDaddr_o=4, RegWrite_o=1.
- srai: opA=0x80000010, Imm=0x404 (shamt 4), ALUOp=11, funct 0100000_101 -> ALUResult_o=0xF8000001.
- Store: ALUOp=00, ALUSrc=1, RS1=0x100, Imm=8, MEMWBfwd=0xDEAD, ForwardB=01, MemWrite=1 -> ALUResult_o=0x108, RS2data_o=0xDEAD, MemWrite_o=1.
- mul: opA=0xFFFFFFFF, opB=3 -> stall_o high for 33 cycles with bubbles in EX/MEM, then ALUResult_o=0xFFFFFFFD, RegWrite_o=1. A second mul (6*7) immediately after -> 42 after another 34 edges.
- EX_MUL_FAST_EN build: mul 6*7 -> ALUResult_o=42 after 1 edge, stall_o never asserted.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared constants and helpers for the RISC-V execute stage.
// ALUOp codes, forwarding select codes, {funct7, funct3} decode constants,
// the EX-stage state encoding and the operand-forwarding mux.
package ex_stage_pkg;

    // Shift-add iterations of the iterative multiplier (one per operand bit)
    localparam int MUL_CYCLES = 32;

    // ALUOp codes from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Forwarding unit select codes
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_RSVD  = 2'b11;

    // {funct7, funct3} decode constants
    localparam logic [9:0] F73_ADD  = 10'b0000000_000;
    localparam logic [9:0] F73_SUB  = 10'b0100000_000;
    localparam logic [9:0] F73_AND  = 10'b0000000_111;
    localparam logic [9:0] F73_OR   = 10'b0000000_110;
    localparam logic [9:0] F73_XOR  = 10'b0000000_100;
    localparam logic [9:0] F73_SLL  = 10'b0000000_001;
    localparam logic [9:0] F73_MUL  = 10'b0000001_000;
    localparam logic [9:0] F73_SRAI = 10'b0100000_101;
    localparam logic [2:0] F3_ADDI  = 3'b000;
    localparam logic [2:0] F3_SRAI  = 3'b101;

    // Execute-stage sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    // Operand forwarding mux; the reserved code behaves like the register path
    function automatic logic [31:0] fwd_sel(
        input logic [1:0]  sel,
        input logic [31:0] reg_data,
        input logic [31:0] exmem_data,
        input logic [31:0] memwb_data
    );
        logic [31:0] res;
        case (sel)
            FWD_EXMEM: res = exmem_data;
            FWD_MEMWB: res = memwb_data;
            FWD_REG:   res = reg_data;
            FWD_RSVD:  res = reg_data;
            default:   res = reg_data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// ex_stage_iter_mul: shift-add multiplier datapath and iteration counter.
// start_i latches the operands and clears product/count; every cycle with
// run_i high performs one shift-add step. done_o flags the final step.
module ex_stage_iter_mul
    import ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        run_i,
    input  logic [31:0] multiplicand_i,
    input  logic [31:0] multiplier_i,
    output logic [31:0] product_o,
    output logic        done_o
);

    localparam int         CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    logic [31:0]      mcand_r;
    logic [31:0]      mplier_r;
    logic [31:0]      prod_r;
    logic [CNT_W-1:0] count_r;

    // Operand latch on start, one shift-add step per run cycle, else hold
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= 32'd0;
            mplier_r <= 32'd0;
            prod_r   <= 32'd0;
            count_r  <= '0;
        end else if (start_i) begin
            mcand_r  <= multiplicand_i;
            mplier_r <= multiplier_i;
            prod_r   <= 32'd0;
            count_r  <= '0;
        end else if (run_i) begin
            prod_r   <= mplier_r[0] ? (prod_r + mcand_r) : prod_r;
            mcand_r  <= {mcand_r[30:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[31:1]};
            count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            prod_r   <= prod_r;
            count_r  <= count_r;
        end
    end

    // Final iteration indicator for the sequencing FSM
    always_comb begin
        done_o = run_i && (count_r == LAST_CNT);
    end

    assign product_o = prod_r;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RISC-V pipeline.
// Forwarding, ALU decode, mul sequencing FSM and the EX/MEM register.
// Build option EX_MUL_FAST_EN: when defined, mul is a single-cycle
// combinational multiply and stall_o is tied low; when undefined, mul runs
// on the iterative shift-add unit and stalls the front of the pipeline.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        ALUSrc_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [31:0] RS1data_i,
    input  logic [31:0] RS2data_i,
    input  logic [31:0] ImmGen_i,
    input  logic [9:0]  funct_7_3_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [1:0]  ForwardA_i,
    input  logic [1:0]  ForwardB_i,
    input  logic [31:0] EXMEMfwd_i,
    input  logic [31:0] MEMWBfwd_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] RS2data_o,
    output logic [4:0]  RDaddr_o,
    output logic        stall_o
);

    logic [31:0] opa_s;
    logic [31:0] fwdb_s;
    logic [31:0] opb_s;
    logic [31:0] alu_res_s;

    logic        regwrite_r;
    logic        memtoreg_r;
    logic        memread_r;
    logic        memwrite_r;
    logic [31:0] alu_res_r;
    logic [31:0] rs2_r;
    logic [4:0]  rd_r;

    // Operand selection: forwarding for both sources, immediate for B
    always_comb begin
        opa_s  = fwd_sel(ForwardA_i, RS1data_i, EXMEMfwd_i, MEMWBfwd_i);
        fwdb_s = fwd_sel(ForwardB_i, RS2data_i, EXMEMfwd_i, MEMWBfwd_i);
        opb_s  = ALUSrc_i ? ImmGen_i : fwdb_s;
    end

    // ALU decode; unsupported encodings produce zero
    always_comb begin
        alu_res_s = 32'd0;
        case (ALUOp_i)
            ALUOP_ADD: alu_res_s = opa_s + opb_s;
            ALUOP_SUB: alu_res_s = opa_s - opb_s;
            ALUOP_RTYPE: begin
                case (funct_7_3_i)
                    F73_ADD: alu_res_s = opa_s + opb_s;
                    F73_SUB: alu_res_s = opa_s - opb_s;
                    F73_AND: alu_res_s = opa_s & opb_s;
                    F73_OR:  alu_res_s = opa_s | opb_s;
                    F73_XOR: alu_res_s = opa_s ^ opb_s;
                    F73_SLL: alu_res_s = opa_s << opb_s[4:0];
`ifdef EX_MUL_FAST_EN
                    F73_MUL: alu_res_s = opa_s * opb_s;
`else
                    F73_MUL: alu_res_s = 32'd0;
`endif
                    default: alu_res_s = 32'd0;
                endcase
            end
            ALUOP_ITYPE: begin
                if (funct_7_3_i[2:0] == F3_ADDI) begin
                    alu_res_s = opa_s + opb_s;
                end else if ((funct_7_3_i[2:0] == F3_SRAI) && (funct_7_3_i == F73_SRAI)) begin
                    alu_res_s = 32'($signed(opa_s) >>> ImmGen_i[4:0]);
                end else begin
                    alu_res_s = 32'd0;
                end
            end
            default: alu_res_s = 32'd0;
        endcase
    end

`ifdef EX_MUL_FAST_EN

    assign stall_o = 1'b0;

    // EX/MEM register: every instruction completes in a single cycle
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            alu_res_r  <= 32'd0;
            rs2_r      <= 32'd0;
            rd_r       <= 5'd0;
        end else begin
            regwrite_r <= RegWrite_i;
            memtoreg_r <= MemtoReg_i;
            memread_r  <= MemRead_i;
            memwrite_r <= MemWrite_i;
            alu_res_r  <= alu_res_s;
            rs2_r      <= fwdb_s;
            rd_r       <= RDaddr_i;
        end
    end

`else

    ex_state_e   state_r;
    logic        is_mul_s;
    logic        mul_start_s;
    logic        mul_run_s;
    logic        mul_done_s;
    logic [31:0] mul_prod_s;
    logic        stall_s;

    // mul detection and stall generation; stall is masked while in reset
    always_comb begin
        is_mul_s    = (ALUOp_i == ALUOP_RTYPE) && (funct_7_3_i == F73_MUL);
        mul_start_s = (state_r == ST_IDLE) && is_mul_s;
        mul_run_s   = (state_r == ST_BUSY);
        stall_s     = start_i && (mul_start_s || mul_run_s);
    end

    assign stall_o = stall_s;

    ex_stage_iter_mul u_iter_mul (
        .clk_i          (clk_i),
        .rst_n          (start_i),
        .start_i        (mul_start_s),
        .run_i          (mul_run_s),
        .multiplicand_i (opa_s),
        .multiplier_i   (fwdb_s),
        .product_o      (mul_prod_s),
        .done_o         (mul_done_s)
    );

    // Sequencing FSM and EX/MEM register: bubbles while stalled, product on DONE
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_r    <= ST_IDLE;
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            memread_r  <= 1'b0;
            memwrite_r <= 1'b0;
            alu_res_r  <= 32'd0;
            rs2_r      <= 32'd0;
            rd_r       <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (is_mul_s) begin
                        state_r    <= ST_BUSY;
                        regwrite_r <= 1'b0;
                        memtoreg_r <= 1'b0;
                        memread_r  <= 1'b0;
                        memwrite_r <= 1'b0;
                        alu_res_r  <= 32'd0;
                        rs2_r      <= 32'd0;
                        rd_r       <= 5'd0;
                    end else begin
                        state_r    <= ST_IDLE;
                        regwrite_r <= RegWrite_i;
                        memtoreg_r <= MemtoReg_i;
                        memread_r  <= MemRead_i;
                        memwrite_r <= MemWrite_i;
                        alu_res_r  <= alu_res_s;
                        rs2_r      <= fwdb_s;
                        rd_r       <= RDaddr_i;
                    end
                end
                ST_BUSY: begin
                    state_r    <= mul_done_s ? ST_DONE : ST_BUSY;
                    regwrite_r <= 1'b0;
                    memtoreg_r <= 1'b0;
                    memread_r  <= 1'b0;
                    memwrite_r <= 1'b0;
                    alu_res_r  <= 32'd0;
                    rs2_r      <= 32'd0;
                    rd_r       <= 5'd0;
                end
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    regwrite_r <= RegWrite_i;
                    memtoreg_r <= MemtoReg_i;
                    memread_r  <= MemRead_i;
                    memwrite_r <= MemWrite_i;
                    alu_res_r  <= mul_prod_s;
                    rs2_r      <= fwdb_s;
                    rd_r       <= RDaddr_i;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    regwrite_r <= 1'b0;
                    memtoreg_r <= 1'b0;
                    memread_r  <= 1'b0;
                    memwrite_r <= 1'b0;
                    alu_res_r  <= 32'd0;
                    rs2_r      <= 32'd0;
                    rd_r       <= 5'd0;
                end
            endcase
        end
    end

`endif

    assign RegWrite_o  = regwrite_r;
    assign MemtoReg_o  = memtoreg_r;
    assign MemRead_o   = memread_r;
    assign MemWrite_o  = memwrite_r;
    assign ALUResult_o = alu_res_r;
    assign RS2data_o   = rs2_r;
    assign RDaddr_o    = rd_r;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector scoreboard bench for ex_stage.
// The driver pushes expected stall/EX-MEM values tagged with the clock edge
// count at which they must hold; the monitor pops and compares on each
// falling edge. Works for both the iterative and EX_MUL_FAST_EN builds.
module tb_ex_stage;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RS1data_i, RS2data_i, ImmGen_i;
    logic [9:0]  funct_7_3_i;
    logic [4:0]  RDaddr_i;
    logic [1:0]  ForwardA_i, ForwardB_i;
    logic [31:0] EXMEMfwd_i, MEMWBfwd_i;
    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
    logic [31:0] ALUResult_o, RS2data_o;
    logic [4:0]  RDaddr_o;
    logic        stall_o;

    ex_stage dut (
        .clk_i(clk_i), .start_i(start_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .ImmGen_i(ImmGen_i),
        .funct_7_3_i(funct_7_3_i), .RDaddr_i(RDaddr_i),
        .ForwardA_i(ForwardA_i), .ForwardB_i(ForwardB_i),
        .EXMEMfwd_i(EXMEMfwd_i), .MEMWBfwd_i(MEMWBfwd_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUResult_o(ALUResult_o), .RS2data_o(RS2data_o),
        .RDaddr_o(RDaddr_o), .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        int          kind;     // 0: stall_o check, 1: EX/MEM register check
        string       name;
        logic        stall;
        logic [3:0]  ctl;      // {RegWrite, MemtoReg, MemRead, MemWrite}
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        chk_rs2;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t it;
    int   edge_cnt = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    // Monitor: compare every expectation scheduled for the current edge count
    always @(negedge clk_i) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
            it = sb_q.pop_front();
            n_cmp++;
            if (it.cyc != edge_cnt) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d reached at edge %0d", it.name, it.cyc, edge_cnt);
            end else if (it.kind == 0) begin
                if (stall_o !== it.stall) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: stall_o got %b want %b", it.name, edge_cnt, stall_o, it.stall);
                end
            end else begin
                if ({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} !== it.ctl ||
                    ALUResult_o !== it.alu || RDaddr_o !== it.rd ||
                    (it.chk_rs2 && RS2data_o !== it.rs2)) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: got ctl=%b alu=%h rs2=%h rd=%0d, want ctl=%b alu=%h rs2=%h rd=%0d",
                             it.name, edge_cnt, {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o},
                             ALUResult_o, RS2data_o, RDaddr_o, it.ctl, it.alu, it.rs2, it.rd);
                end
            end
        end
    end

    task automatic push_stall(input int cyc, input string name, input logic s);
        exp_t e;
        e.cyc = cyc; e.kind = 0; e.name = name; e.stall = s;
        e.ctl = 4'd0; e.alu = 32'd0; e.rs2 = 32'd0; e.chk_rs2 = 1'b0; e.rd = 5'd0;
        sb_q.push_back(e);
    endtask

    task automatic push_reg(input int cyc, input string name, input logic [3:0] ctl,
                            input logic [31:0] alu, input logic [31:0] rs2,
                            input logic chk_rs2, input logic [4:0] rd);
        exp_t e;
        e.cyc = cyc; e.kind = 1; e.name = name; e.stall = 1'b0;
        e.ctl = ctl; e.alu = alu; e.rs2 = rs2; e.chk_rs2 = chk_rs2; e.rd = rd;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [9:0] f,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic alusrc, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] exm, input logic [31:0] mwb,
                         input logic [3:0] ctl, input logic [4:0] rd);
        ALUOp_i = aluop; funct_7_3_i = f;
        RS1data_i = rs1; RS2data_i = rs2; ImmGen_i = imm; ALUSrc_i = alusrc;
        ForwardA_i = fa; ForwardB_i = fb; EXMEMfwd_i = exm; MEMWBfwd_i = mwb;
        {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i} = ctl;
        RDaddr_i = rd;
    endtask

    // Single-cycle instruction: no stall now, result after the next edge
    task automatic op(input string name, input logic [1:0] aluop, input logic [9:0] f,
                      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                      input logic alusrc, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] exm, input logic [31:0] mwb,
                      input logic [3:0] ctl, input logic [4:0] rd,
                      input logic [31:0] exp_alu, input logic [31:0] exp_rs2);
        @(posedge clk_i); #2;
        drive(aluop, f, rs1, rs2, imm, alusrc, fa, fb, exm, mwb, ctl, rd);
        push_stall(edge_cnt, {name, "_stall"}, 1'b0);
        push_reg(edge_cnt + 1, name, ctl, exp_alu, exp_rs2, 1'b1, rd);
    endtask

    // Expectations for a mul already presented at edge count e; holds inputs
    task automatic mul_expect(input string name, input int e, input logic [31:0] rs2,
                              input logic [4:0] rd, input logic [31:0] exp_p);
`ifdef EX_MUL_FAST_EN
        push_stall(e, {name, "_stall"}, 1'b0);
        push_reg(e + 1, name, 4'b1000, exp_p, rs2, 1'b1, rd);
`else
        for (int k = 0; k <= 33; k++) begin
            push_stall(e + k, {name, "_stall"}, (k < 33) ? 1'b1 : 1'b0);
            if (k >= 1) push_reg(e + k, {name, "_bubble"}, 4'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        end
        push_reg(e + 34, name, 4'b1000, exp_p, rs2, 1'b1, rd);
        repeat (33) @(posedge clk_i);
`endif
    endtask

    task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_p);
        @(posedge clk_i); #2;
        drive(2'b10, 10'b0000001_000, a, b, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 4'b1000, rd);
        mul_expect(name, edge_cnt, b, rd, exp_p);
    endtask

    initial begin
        start_i = 1'b0;
        drive(2'b00, 10'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 5'd0);

        // Reset held with random inputs (last one a mul): outputs and stall stay 0
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #2;
            drive(2'($urandom), 10'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                  2'($urandom), 2'($urandom), $urandom, $urandom, 4'($urandom), 5'($urandom));
            if (i == 4) begin
                ALUOp_i = 2'b10; funct_7_3_i = 10'b0000001_000;
            end
            push_stall(edge_cnt, "reset_stall", 1'b0);
            push_reg(edge_cnt, "reset_regs", 4'd0, 32'd0, 32'd0, 1'b1, 5'd0);
        end
        drive(2'b00, 10'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 5'd0);
        start_i = 1'b1;

`ifndef EX_MUL_FAST_EN
        // Reset asserted 10 cycles into a mul, then released with the mul still presented
        begin
            int e;
            @(posedge clk_i); #2;
            drive(2'b10, 10'b0000001_000, 32'h1234, 32'h10, 32'd0, 1'b0, 2'b00, 2'b00,
                  32'd0, 32'd0, 4'b1000, 5'd3);
            e = edge_cnt;
            for (int k = 0; k < 10; k++) begin
                push_stall(e + k, "abort_stall", 1'b1);
                if (k >= 1) push_reg(e + k, "abort_bubble", 4'd0, 32'd0, 32'd0, 1'b0, 5'd0);
            end
            repeat (10) @(posedge clk_i);
            #2;
            start_i = 1'b0;
            push_stall(edge_cnt, "abort_rst_stall", 1'b0);
            push_reg(edge_cnt, "abort_rst_regs", 4'd0, 32'd0, 32'd0, 1'b1, 5'd0);
            @(posedge clk_i); #2;
            start_i = 1'b1;
            mul_expect("restart_mul", edge_cnt, 32'h10, 5'd3, 32'h0001_2340);
        end
`endif

        //  name         aluop  funct              rs1           rs2           imm           src   fa     fb     exmem     memwb      ctl      rd     exp_alu       exp_rs2
        op("add_fwdA",  2'b10, 10'b0000000_000, 32'd5,        32'd3,        32'd0,        1'b0, 2'b10, 2'b00, 32'd7,    32'd0,     4'b1000, 5'd4,  32'd10,       32'd3);
        op("sub_r",     2'b10, 10'b0100000_000, 32'd20,       32'd7,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd5,  32'd13,       32'd7);
        op("sub_wrap",  2'b01, 10'b1111111_111, 32'd3,        32'd5,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b0000, 5'd0,  32'hFFFFFFFE, 32'd5);
        op("and_r",     2'b10, 10'b0000000_111, 32'hF0F01234, 32'h0FF0FF00, 32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd6,  32'h00F01200, 32'h0FF0FF00);
        op("or_r",      2'b10, 10'b0000000_110, 32'hF0F01234, 32'h0FF0FF00, 32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd7,  32'hFFF0FF34, 32'h0FF0FF00);
        op("xor_r",     2'b10, 10'b0000000_100, 32'hF0F01234, 32'h0FF0FF00, 32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd8,  32'hFF00ED34, 32'h0FF0FF00);
        op("sll_shamt", 2'b10, 10'b0000000_001, 32'd1,        32'h23,       32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd9,  32'd8,        32'h23);
        op("srai",      2'b11, 10'b0100000_101, 32'h80000010, 32'h55,       32'h404,      1'b1, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd10, 32'hF8000001, 32'h55);
        op("srli_unsup",2'b11, 10'b0000000_101, 32'h80000010, 32'h55,       32'h4,        1'b1, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd11, 32'd0,        32'h55);
        op("addi_wrap", 2'b11, 10'b0000000_000, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b1, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd12, 32'd0,        32'd0);
        op("illegal_r", 2'b10, 10'b0000000_010, 32'd9,        32'd9,        32'd0,        1'b0, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1000, 5'd13, 32'd0,        32'd9);
        op("store",     2'b00, 10'b0000000_010, 32'h100,      32'h1111,     32'd8,        1'b1, 2'b00, 2'b01, 32'd0,    32'hDEAD,  4'b0001, 5'd0,  32'h108,      32'hDEAD);
        op("load",      2'b00, 10'b0000000_010, 32'h200,      32'h77,       32'hFFFFFFFC, 1'b1, 2'b00, 2'b00, 32'd0,    32'd0,     4'b1110, 5'd14, 32'h1FC,      32'h77);
        op("fwd11_reg", 2'b00, 10'd0,           32'd100,      32'd1,        32'd0,        1'b0, 2'b11, 2'b11, 32'd999,  32'd555,   4'b1000, 5'd15, 32'd101,      32'd1);
        op("fwd_memwb", 2'b00, 10'd0,           32'd0,        32'd2,        32'd0,        1'b0, 2'b01, 2'b00, 32'd999,  32'd40,    4'b1000, 5'd16, 32'd42,       32'd2);

        mul_op("mul_neg1x3", 32'hFFFFFFFF, 32'd3, 5'd17, 32'hFFFFFFFD);
        mul_op("mul_6x7",    32'd6,        32'd7, 5'd18, 32'd42);
        op("add_after_mul", 2'b10, 10'b0000000_000, 32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 4'b1000, 5'd19, 32'd2, 32'd1);

        @(posedge clk_i); #2;
        drive(2'b00, 10'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 4'd0, 5'd0);
        for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
